// File: rtl/ctrl_pkg.sv
// ctrl_pkg: types and defaults shared by the ctrl_* pipeline control stages
// (fetch/decode/execute).
package ctrl_pkg;

  localparam int CTRL_ADDR_W = 16;
  localparam int CTRL_IR_W   = 16;

  localparam logic [CTRL_IR_W-1:0] CTRL_NOP = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_if_state_t;

  typedef struct packed {
    logic [CTRL_ADDR_W-1:0] addr;
    logic [CTRL_IR_W-1:0]   ir;
  } fetch_entry_t;

endpackage

// File: rtl/ctrl_if_fifo.sv
// ctrl_if_fifo: synchronous prefetch FIFO of fetch entries with push/pop/flush.
// DEPTH must be a power of two so the pointers wrap on their own.
module ctrl_if_fifo
  import ctrl_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; it is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) slots[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/ctrl_if.sv
// ctrl_if: instruction fetch stage; fetches words into a prefetch FIFO and presents the
// head to decode, with stall backpressure and branch redirect. CTRL_IF_PERF_EN adds o_bubble_cnt.
//
// state | meaning
// IDLE  | first cycle after reset, no fetch activity
// RUN   | issuing fetches, returned words pushed into the FIFO
// DRAIN | redirected with a request still outstanding; its word is discarded on ack
module ctrl_if
  import ctrl_pkg::*;
#(
  parameter int                ADDR_W     = CTRL_ADDR_W,
  parameter int                IR_W       = CTRL_IR_W,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [IR_W-1:0]   i_imem_data,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [IR_W-1:0]   o_ir_cache,
  output logic              o_ir_valid,
  output logic [ADDR_W-1:0] o_pc
`ifdef CTRL_IF_PERF_EN
  ,
  output logic [15:0]       o_bubble_cnt
`endif
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [IR_W-1:0]   ir;
  } entry_t;

  ctrl_if_state_t    state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] pc_hold;
  logic [IR_W-1:0]   ir_hold;
  logic              ack_acc;
  logic              push;
  logic              pop;
  logic              issue_ok;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              fifo_full;
  logic              fifo_empty;
  entry_t            push_entry;
  entry_t            head;

  // A branch outranks push and pop: the head and any returning word are wrong-path.
  assign ack_acc    = o_imem_req && i_imem_ack;
  assign push       = ack_acc && (state == RUN) && !i_branch_taken && !fifo_full;
  assign pop        = o_ir_valid && !i_stall && !i_branch_taken;
  assign push_entry = '{addr: fetch_pc, ir: i_imem_data};

  assign o_imem_addr = fetch_pc;
  assign o_ir_valid  = !fifo_empty;
  assign o_ir_cache  = fifo_empty ? ir_hold : head.ir;
  assign o_pc        = fifo_empty ? pc_hold : head.addr;

  always_comb begin
    cnt_nxt = fifo_count;
    if (push && !pop)      cnt_nxt = fifo_count + 1'b1;
    else if (!push && pop) cnt_nxt = fifo_count - 1'b1;
  end

  // After this cycle's push/pop nothing is outstanding, so room in the FIFO is the only limit.
  assign issue_ok = (cnt_nxt < DEPTH_CNT);

  ctrl_if_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (i_branch_taken),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      o_imem_req <= 1'b0;
      fetch_pc   <= RESET_PC;
      target_q   <= RESET_PC;
      pc_hold    <= RESET_PC;
      ir_hold    <= IR_W'(CTRL_NOP);
    end else begin
      if (!fifo_empty) begin
        pc_hold <= head.addr;
        ir_hold <= head.ir;
      end
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (i_branch_taken) begin
            if (o_imem_req && !i_imem_ack) begin
              state    <= DRAIN;
              target_q <= i_branch_target;
            end else begin
              fetch_pc   <= i_branch_target;
              o_imem_req <= 1'b1;
            end
          end else if (ack_acc) begin
            fetch_pc   <= fetch_pc + 1'b1;
            o_imem_req <= issue_ok;
          end else if (!o_imem_req) begin
            o_imem_req <= issue_ok;
          end
        end
        DRAIN: begin
          if (ack_acc) begin
            state      <= RUN;
            o_imem_req <= 1'b1;
            fetch_pc   <= i_branch_taken ? i_branch_target : target_q;
          end else if (i_branch_taken) begin
            target_q <= i_branch_target;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CTRL_IF_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_bubble_cnt <= '0;
    end else if (state != IDLE && fifo_empty && o_bubble_cnt != 16'hFFFF) begin
      o_bubble_cnt <= o_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_if.sv
// tb_ctrl_if: directed and randomized checks of ctrl_if against an in-order program
// stream model (next pc = pc+1, redirected by branches) and a latency-programmable memory.
module tb_ctrl_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic        o_imem_req, o_ir_valid;
  logic [15:0] o_imem_addr, o_ir_cache, o_pc;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic        i_stall = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [15:0] i_branch_target = 16'h0000;
  logic        req2, valid2, ack2;
  logic [15:0] addr2, ir2, pc2, data2;
  logic        stall2 = 1'b0;
  logic        br2 = 1'b0;
  logic [15:0] tgt2 = 16'h0000;
`ifdef CTRL_IF_PERF_EN
  logic [15:0] bubble_cnt, bubble_cnt2;
`endif

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  int          mem_lat = 0;
  bit          lat_rand = 1'b0;
  logic [15:0] exp_pc = 16'h0000;

  always #5 clk = ~clk;

  ctrl_if #(.ADDR_W(16), .IR_W(16), .FIFO_DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
    .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .o_ir_cache(o_ir_cache), .o_ir_valid(o_ir_valid), .o_pc(o_pc)
`ifdef CTRL_IF_PERF_EN
    , .o_bubble_cnt(bubble_cnt)
`endif
  );

  ctrl_if #(.ADDR_W(16), .IR_W(16), .FIFO_DEPTH(2), .RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst2),
    .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_ack(ack2), .i_imem_data(data2),
    .i_stall(stall2), .i_branch_taken(br2), .i_branch_target(tgt2),
    .o_ir_cache(ir2), .o_ir_valid(valid2), .o_pc(pc2)
`ifdef CTRL_IF_PERF_EN
    , .o_bubble_cnt(bubble_cnt2)
`endif
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory for dut: one request at a time, latency 0..3 cycles, req/addr must hold until ack.
  initial begin : mem
    int wcnt;
    logic [15:0] held;
    wcnt = -1;
    held = 16'h0000;
    i_imem_ack = 1'b0;
    i_imem_data = 16'h0000;
    forever begin
      @(negedge clk); #1;
      if (rst || !o_imem_req) begin
        i_imem_ack = 1'b0;
        wcnt = -1;
      end else begin
        if (wcnt < 0) begin
          wcnt = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
          held = o_imem_addr;
        end else begin
          chk("req_addr_hold", o_imem_addr, held);
        end
        if (wcnt == 0) begin
          i_imem_ack = 1'b1;
          i_imem_data = mem_word(o_imem_addr);
          wcnt = -1;
        end else begin
          i_imem_ack = 1'b0;
          i_imem_data = 16'($urandom);
          wcnt--;
        end
      end
    end
  end

  initial begin : mem2
    ack2 = 1'b0;
    data2 = 16'h0000;
    forever begin
      @(negedge clk); #1;
      ack2 = req2;
      data2 = mem_word(addr2);
    end
  end

  // Program-stream scoreboard: every consumed instruction must be the next in program order.
  initial begin : mon
    forever begin
      @(negedge clk); #4;
      if (rst) continue;
      if (i_branch_taken) begin
        exp_pc = i_branch_target;
      end else if (o_ir_valid && !i_stall) begin
        chk("stream_pc", o_pc, exp_pc);
        chk("stream_ir", o_ir_cache, mem_word(exp_pc));
        exp_pc = exp_pc + 16'd1;
        consumed++;
      end
    end
  end

  initial begin : mon2
    int n;
    logic [15:0] exp5 [4];
    n = 0;
    exp5 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    @(negedge rst2);
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk); #4;
      if (valid2) begin
        chk("t5_wrap_pc", pc2, exp5[n]);
        chk("t5_wrap_ir", ir2, mem_word(exp5[n]));
        n++;
      end
    end
    chk("t5_count", n, 4);
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acks;
    bit found;
    logic [15:0] held;

    // Reset values
    repeat (2) @(negedge clk);
    #4;
    chk("rst_req", o_imem_req, 0);
    chk("rst_addr", o_imem_addr, 16'h0000);
    chk("rst_ir", o_ir_cache, 16'h0000);
    chk("rst_valid", o_ir_valid, 0);
    chk("rst_pc", o_pc, 16'h0000);
    chk("rst2_pc", pc2, 16'hFFFE);
    chk("rst2_addr", addr2, 16'hFFFE);

    // T1: 0-wait memory, no stall
    @(negedge clk);
    exp_pc = 16'h0000;
    rst = 1'b0;
    rst2 = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #4;
      if (o_imem_req) found = 1;
    end
    chk("t1_req_seen", found, 1);
    chk("t1_first_addr", o_imem_addr, 16'h0000);
    chk("t1_valid_before_ack", o_ir_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #4;
      chk("t1_valid", o_ir_valid, 1);
      chk("t1_pc", o_pc, 32'(k));
    end

    // T2: stall from reset, two entries absorbed then fetch stops
    @(negedge clk);
    rst = 1'b1;
    i_stall = 1'b1;
    exp_pc = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #4;
      if (o_imem_req && i_imem_ack) acks++;
    end
    chk("t2_acks", acks, 2);
    chk("t2_req_low", o_imem_req, 0);
    chk("t2_valid", o_ir_valid, 1);
    chk("t2_head_pc", o_pc, 16'h0000);
    chk("t2_head_ir", o_ir_cache, mem_word(16'h0000));
    @(negedge clk);
    i_stall = 1'b0;
    #4;
    chk("t2_first_pc", o_pc, 16'h0000);
    repeat (8) @(negedge clk);

    // T3: branch while a 3-cycle request is waiting
    mem_lat = 3;
    found = 0;
    held = 16'h0000;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #4;
      if (o_imem_req && !i_imem_ack) begin
        found = 1;
        held = o_imem_addr;
      end
    end
    chk("t3_wait_seen", found, 1);
    @(negedge clk);
    i_branch_taken = 1'b1;
    i_branch_target = 16'h0040;
    #4;
    chk("t3_pending", o_imem_req && !i_imem_ack, 1);
    @(negedge clk);
    i_branch_taken = 1'b0;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      if (c > 0) @(negedge clk);
      #4;
      chk("t3_req_held", o_imem_req, 1);
      chk("t3_addr_held", o_imem_addr, held);
      if (i_imem_ack) found = 1;
    end
    chk("t3_ack_seen", found, 1);
    @(negedge clk); #4;
    chk("t3_next_req", o_imem_req, 1);
    chk("t3_next_addr", o_imem_addr, 16'h0040);
    found = 0;
    for (int c = 0; c < 15 && !found; c++) begin
      @(negedge clk); #4;
      if (o_ir_valid) found = 1;
    end
    chk("t3_valid_seen", found, 1);
    chk("t3_first_pc", o_pc, 16'h0040);

    // T4: branch coinciding with ack and pop while the FIFO budget is used up
    mem_lat = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #4;
      if (o_imem_req && i_imem_ack && o_ir_valid) found = 1;
    end
    chk("t4_steady_seen", found, 1);
    @(negedge clk);
    i_branch_taken = 1'b1;
    i_branch_target = 16'h0100;
    #4;
    chk("t4_ack_pop", o_imem_req && i_imem_ack && o_ir_valid, 1);
    @(negedge clk);
    i_branch_taken = 1'b0;
    #4;
    chk("t4_flushed", o_ir_valid, 0);
    chk("t4_next_req", o_imem_req, 1);
    chk("t4_next_addr", o_imem_addr, 16'h0100);
    repeat (4) @(negedge clk);

    // Randomized traffic: stalls, latencies, branches (some near the wrap point)
    lat_rand = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      i_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) begin
        i_branch_taken = 1'b1;
        i_branch_target = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      end else begin
        i_branch_taken = 1'b0;
      end
    end
    @(negedge clk);
    i_stall = 1'b0;
    i_branch_taken = 1'b0;
    lat_rand = 1'b0;
    repeat (10) @(negedge clk);
    chk("rand_progress", consumed > 400, 1);

    // T6: reset with a request outstanding
    mem_lat = 3;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #4;
      if (o_imem_req && !i_imem_ack) found = 1;
    end
    chk("t6_wait_seen", found, 1);
    @(negedge clk);
    rst = 1'b1;
    exp_pc = 16'h0000;
    #2;
    chk("t6_req", o_imem_req, 0);
    chk("t6_addr", o_imem_addr, 16'h0000);
    chk("t6_valid", o_ir_valid, 0);
    chk("t6_pc", o_pc, 16'h0000);
    chk("t6_ir", o_ir_cache, 16'h0000);
`ifdef CTRL_IF_PERF_EN
    chk("t6_bubble_rst", bubble_cnt, 0);
`endif
    mem_lat = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    chk("t6_valid_after", o_ir_valid, 1);
`ifdef CTRL_IF_PERF_EN
    chk("t6_bubbles", bubble_cnt, 2);
    chk("t5_bubbles", bubble_cnt2, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
